word_serializer: RTL and testbench
==================================

WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bits per word taken from I[WIDTH-1:0]; legal values are 2..8 when DDR=0 and 4, 6 or 8 when DDR=1.
REQ-002 The block SHALL have parameter DDR, default 0: 0 = one bit per clock (SDR), 1 = two bits per clock.
REQ-003 CLK  in  1  the single clock; all state is updated on its rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 CE  in  1  clock enable; when low, all state holds and RD=0.
REQ-006 I  in  8  word from the upstream 8-bit ROM; valid on the cycle after that ROM samples RD=1 (one-cycle read latency).
REQ-007 RD  out  1  read strobe to the ROM; each cycle it is high advances the ROM by one word.
REQ-008 O  out  2  serial data; O[0] is the first/rising-edge bit and O[1] is the second/falling-edge bit; when DDR=0, O[1]=O[0].
REQ-009 FRM  out  1  high during the cycle that presents the first bit(s) of a word.

Function
REQ-010 Let B = 1+DDR and N = WIDTH/B (cycles per word); N SHALL be at least 2 for every legal parameter set.
REQ-011 The state machine SHALL have the states IDLE, PRIME, LOAD and RUN, with IDLE as the reset state.
REQ-012 IDLE SHALL go to PRIME on the first edge with CE=1; RD=0 in IDLE.
REQ-013 PRIME SHALL drive RD=CE and go to LOAD on an edge with CE=1.
REQ-014 LOAD SHALL, on an edge with CE=1, load the WIDTH-bit shift register sh<=I[WIDTH-1:0], set cnt<=0 and go to RUN.
REQ-015 In RUN, each edge with CE=1 SHALL shift sh left by B bits and increment cnt; at cnt=N-1 it SHALL instead load sh<=I[WIDTH-1:0] and set cnt<=0.
REQ-016 RD SHALL equal CE AND (state=RUN) AND (cnt=N-2), so that the next word is valid on I during cnt=N-1 and words are transmitted back-to-back with no gap.
REQ-017 O[0] SHALL equal sh[WIDTH-1]; O[1] SHALL equal sh[WIDTH-2] when DDR=1, otherwise sh[WIDTH-1].
REQ-018 O SHALL be taken directly from sh register bits, with no combinational logic between sh and O.
REQ-019 Bit order SHALL be MSB-first within I[WIDTH-1:0]; I[7:WIDTH] SHALL be ignored.
REQ-020 FRM SHALL equal (state=RUN) AND (cnt=0); it is 0 in IDLE, PRIME and LOAD.
REQ-021 RD SHALL pulse exactly once per transmitted word after priming, with no RD pulse in any other RUN cycle.
REQ-022 When CE is low in any state, including cnt=N-1 with a word pending on I, there SHALL be no change to state, cnt or sh, and RD=0; the pending word is not lost because the ROM output holds while RD=0.
REQ-023 cnt SHALL be 3 bits wide and SHALL wrap only at N-1, never by overflow.
REQ-024 The block SHALL run indefinitely; wrap-around of the upstream ROM address is transparent to it.

Reset
REQ-025 RST=1 SHALL asynchronously force state=IDLE, cnt=0, sh=0, so that O=2'b00, FRM=0 and RD=0 for as long as RST is high.
REQ-026 RST asserted mid-word SHALL abort the word immediately; after release the block SHALL re-prime through IDLE, PRIME and LOAD, and SHALL NOT output any partial word.
REQ-027 The upstream ROM SHALL share the same RST, so that the first word after any reset is ROM word 0.

Verification
REQ-028 WIDTH=8, DDR=0, CE=1, ROM words 0x9D, 0xFE: release RST -> RD high for 1 cycle (PRIME), then 1 LOAD cycle, then O[0]=1,0,0,1,1,1,0,1,1,1,1,1,1,1,1,0 with FRM on bits 0 and 8, and RD high in RUN cnt=6.
REQ-029 WIDTH=8, DDR=1, same words -> {O[0],O[1]} per cycle = (1,0),(0,1),(1,1),(0,1), then (1,1),(1,1),(1,1),(1,0); FRM every 4th cycle; RD at cnt=2.
REQ-030 WIDTH=4, DDR=0 -> the low nibbles 0xD and 0xE are sent as 1,1,0,1 then 1,1,1,0; FRM every 4 cycles.
REQ-031 CE held low for 3 cycles at cnt=7 (WIDTH=8, SDR) -> O, FRM and RD frozen with RD=0 while CE is low; the next word 0xFE follows intact, and exactly one RD pulse occurs per word.
REQ-032 RST pulsed in RUN at cnt=3 -> O=00, FRM=0 and RD=0 immediately; after release the stream restarts with 0x9D (first bit 1, FRM=1) after PRIME and LOAD.
REQ-033 Word count check over 64 words -> the RD pulse count equals the FRM count plus 1 (the priming read), and the serial data matches the 32-entry ROM contents repeated twice.

Source files
------------

// File: rtl/word_serializer.sv
// word_serializer: streams WIDTH-bit words from a one-cycle-latency ROM
// as an MSB-first serial stream, one (SDR) or two (DDR) bits per clock.
`timescale 1ns/1ps
module word_serializer #(
    parameter int WIDTH = 8,
    parameter int DDR   = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic [7:0] I,
    output logic       RD,
    output logic [1:0] O,
    output logic       FRM
);
    localparam int B = 1 + DDR;
    localparam int N = WIDTH / B;
    localparam logic [2:0] CNT_LAST = 3'(N - 1);
    localparam logic [2:0] CNT_RD   = 3'(N - 2);

    typedef enum logic [1:0] {IDLE, PRIME, LOAD, RUN} state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] shifted;
    logic             frm;

    assign word    = I[WIDTH-1:0];
    assign shifted = {sh[WIDTH-B-1:0], {B{1'b0}}};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            frm   <= 1'b0;
        end else if (CE) begin
            unique case (state)
                IDLE:  state <= PRIME;
                PRIME: state <= LOAD;
                LOAD: begin
                    sh    <= word;
                    cnt   <= '0;
                    frm   <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    // Next word was fetched at CNT_RD, so it is on I now.
                    if (cnt == CNT_LAST) begin
                        sh  <= word;
                        cnt <= '0;
                        frm <= 1'b1;
                    end else begin
                        sh  <= shifted;
                        cnt <= cnt + 3'd1;
                        frm <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign RD  = CE && ((state == PRIME) ||
                        ((state == RUN) && (cnt == CNT_RD)));
    assign FRM = frm;

    assign O[0] = sh[WIDTH-1];
    generate
        if (DDR != 0) begin : g_ddr
            assign O[1] = sh[WIDTH-2];
        end else begin : g_sdr
            assign O[1] = sh[WIDTH-1];
        end
    endgenerate
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: SDR8, DDR8 and SDR4 serializers run side by side
// from a shared ROM image; a scoreboard checks words and strobes.
`timescale 1ns/1ps
module tb_word_serializer;
    localparam int NI = 3;

    logic            clk  = 1'b0;
    logic            rst  = 1'b1;
    logic            ce   = 1'b0;
    logic            done = 1'b0;
    logic [NI-1:0]   rd;
    logic [NI-1:0]   frm;
    logic [2*NI-1:0] o;
    logic [7:0]      rom [32];

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    function automatic int wid(input int g);
        return (g == 2) ? 4 : 8;
    endfunction

    function automatic int bpc(input int g);
        return (g == 1) ? 2 : 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = (g == 2) ? 4 : 8;
        localparam int D = (g == 1) ? 1 : 0;
        logic [7:0] data;
        logic [4:0] addr;

        word_serializer #(.WIDTH(W), .DDR(D)) dut (
            .CLK(clk),
            .RST(rst),
            .CE (ce),
            .I  (data),
            .RD (rd[g]),
            .O  (o[2*g +: 2]),
            .FRM(frm[g])
        );

        // One-cycle-latency ROM sharing the serializer reset.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                data <= '0;
                addr <= '0;
            end else if (rd[g]) begin
                data <= rom[addr];
                addr <= addr + 5'd1;
            end
        end
    end

    function automatic int qsize(input int g);
        case (g)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int g, input logic [7:0] v);
        case (g)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic qpop(input int g, output logic [7:0] v);
        case (g)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s[u%0d]: got %0h, want %0h at %0t",
                      name, g, act, exp, $time);
    endtask

    // Stimulus: CE stall over the first word boundary, mid-word reset,
    // then a long free-running stretch.
    initial begin
        rom = '{8'h9D, 8'hFE, 8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80,
                8'h3C, 8'hC3, 8'h7E, 8'h81, 8'h12, 8'h34, 8'h56, 8'h78,
                8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'h55, 8'hAA, 8'h66,
                8'h99, 8'h24, 8'h42, 8'hE7, 8'h18, 8'h6B, 8'hB6, 8'h2D};
        rst = 1'b1;
        ce  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // u0 finishes 0x9D, 0xFE before the reset; u1, u2 finish four words.
        for (int i = 0; i < 2; i++) qpush(0, rom[i]);
        for (int i = 0; i < 4; i++) begin
            qpush(1, rom[i]);
            qpush(2, rom[i]);
        end
        rst = 1'b0;
        for (int j = 0; j < 25; j++) begin
            ce = !(j >= 10 && j <= 12);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        ce  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 64; i++) qpush(0, rom[i % 32]);
        for (int i = 0; i < 128; i++) begin
            qpush(1, rom[i % 32]);
            qpush(2, rom[i % 32]);
        end
        rst = 1'b0;
        for (int j = 0; j < 515; j++) begin
            @(posedge clk);
            #1;
        end
        done = 1'b1;
    end

    int         ph  [NI];
    int         nb  [NI];
    int         rdc [NI];
    int         frc [NI];
    logic [7:0] acc [NI];
    logic [1:0] po  [NI];
    logic       pfrm[NI];
    logic       prev_ce  = 1'b0;
    logic       prev_rst = 1'b1;
    logic       fresh;
    logic [1:0] cur;
    logic [7:0] e;
    logic [7:0] mask;
    int         k;
    int         b;
    int         n;

    // Monitor: a sample is fresh when the previous edge advanced the DUT.
    always @(negedge clk) begin
        if (done) begin
            for (int g = 0; g < NI; g++) begin
                n = wid(g) / bpc(g);
                chk("words_left", g, qsize(g), 0);
                chk("frm_count", g, frc[g], 512 / n);
                chk("rd_count", g, rdc[g], frc[g] + 1);
            end
            $display("%0d/%0d checks passed", passes, checks);
            $finish;
        end else if (rst) begin
            for (int g = 0; g < NI; g++) begin
                chk("rst_o", g, o[2*g +: 2], 0);
                chk("rst_frm", g, frm[g], 0);
                chk("rst_rd", g, rd[g], 0);
                if (!prev_rst) chk("words_done", g, qsize(g), 0);
                ph[g]  = -1;
                nb[g]  = 0;
                acc[g] = '0;
                rdc[g] = 0;
                frc[g] = 0;
            end
            prev_rst = 1'b1;
            prev_ce  = ce;
        end else begin
            fresh = prev_rst || prev_ce;
            for (int g = 0; g < NI; g++) begin
                b    = bpc(g);
                n    = wid(g) / b;
                mask = (wid(g) == 4) ? 8'h0F : 8'hFF;
                cur  = o[2*g +: 2];
                if (fresh) begin
                    ph[g]++;
                end else begin
                    chk("hold_o", g, cur, po[g]);
                    chk("hold_frm", g, frm[g], pfrm[g]);
                end
                if (ph[g] < 3) begin
                    chk("pre_o", g, cur, 0);
                    chk("pre_frm", g, frm[g], 0);
                    chk("pre_rd", g, rd[g], (ph[g] == 1) && ce);
                end else begin
                    k = (ph[g] - 3) % n;
                    chk("frm", g, frm[g], k == 0);
                    chk("rd", g, rd[g], ce && (k == n - 2));
                    if (b == 1) chk("o_dup", g, cur[1], cur[0]);
                    if (fresh) begin
                        if (b == 2) acc[g] = (acc[g] << 2) | {6'b0, cur[0], cur[1]};
                        else        acc[g] = (acc[g] << 1) | {7'b0, cur[0]};
                        nb[g]++;
                        if (nb[g] == n) begin
                            checks++;
                            if (qsize(g) == 0) begin
                                $display("FAIL word[u%0d]: got %0h, want none pending at %0t",
                                         g, acc[g], $time);
                            end else begin
                                qpop(g, e);
                                if (acc[g] === (e & mask)) passes++;
                                else $display("FAIL word[u%0d]: got %0h, want %0h at %0t",
                                              g, acc[g], e & mask, $time);
                            end
                            nb[g]  = 0;
                            acc[g] = '0;
                        end
                    end
                end
                if (rd[g]) rdc[g]++;
                if (fresh && frm[g]) frc[g]++;
                po[g]   = cur;
                pfrm[g] = frm[g];
            end
            prev_rst = 1'b0;
            prev_ce  = ce;
        end
    end
endmodule
